// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: issues one request per load/store, holds the
// pipeline until the memory acknowledges or the wait budget runs out, and resolves branches.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        Branch,
  input  logic        Zero,
  input  logic [31:0] Add,
  input  logic [31:0] ALUResult,
  input  logic [31:0] ReadData2,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic [31:0] ReadData_Out,
  output logic        PCSrc,
  output logic [31:0] BranchTarget,
  output logic        align_err,
  output logic        mem_err,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      next_state;
  logic [7:0]  wait_cnt;
  logic        access;
  logic        aligned;
  logic        start;
  logic        misaligned;
  logic        ack_hit;
  logic        timeout_hit;

  assign access      = MemRead | MemWrite;
  assign aligned     = (ALUResult[1:0] == 2'b00);
  assign start       = (state == IDLE) && access && aligned;
  assign misaligned  = (state == IDLE) && access && !aligned;
  assign ack_hit     = (state == ACCESS) && mem_ack;
  // A timeout only fires when no ack arrives in the last wait cycle.
  assign timeout_hit = (state == ACCESS) && !mem_ack && (wait_cnt == LAST_WAIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = ACCESS;
      ACCESS:  if (ack_hit || timeout_hit) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    stall = 1'b0;
    if (reset) begin
      case (state)
        IDLE:    stall = start;
        ACCESS:  stall = 1'b1;
        default: stall = 1'b0;
      endcase
    end
    PCSrc        = Branch & Zero & ~stall;
    BranchTarget = Add;
    fsm_state    = state;
  end

  // Handshake: mem_req rises on ACCESS entry with addr/wdata/we registered alongside, and
  // all of them stay frozen until the cycle in which mem_ack is seen or the wait budget ends.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 32'd0;
      mem_wdata    <= 32'd0;
      ReadData_Out <= 32'd0;
      align_err    <= 1'b0;
      mem_err      <= 1'b0;
      wait_cnt     <= 8'd0;
    end else begin
      align_err <= misaligned;
      mem_err   <= timeout_hit;
      case (state)
        IDLE: begin
          if (start) begin
            mem_req   <= 1'b1;
            mem_addr  <= ALUResult;
            mem_wdata <= ReadData2;
            mem_we    <= MemWrite & ~MemRead;
            wait_cnt  <= 8'd0;
          end
        end
        ACCESS: begin
          if (ack_hit) begin
            mem_req <= 1'b0;
            if (!mem_we) ReadData_Out <= mem_rdata;
          end else if (timeout_hit) begin
            mem_req <= 1'b0;
            if (!mem_we) ReadData_Out <= 32'd0;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit: each transaction's expected timing, stall count,
// error pulses and load result are derived from the access rules, not the RTL structure.
module tb_mem_access_unit;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemRead, MemWrite, Branch, Zero;
  logic [31:0] Add, ALUResult, ReadData2;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        stall;
  logic [31:0] ReadData_Out;
  logic        PCSrc;
  logic [31:0] BranchTarget;
  logic        align_err, mem_err;
  logic [1:0]  fsm_state;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_rdo;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .Zero(Zero),
    .Add(Add), .ALUResult(ALUResult), .ReadData2(ReadData2),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall(stall), .ReadData_Out(ReadData_Out), .PCSrc(PCSrc), .BranchTarget(BranchTarget),
    .align_err(align_err), .mem_err(mem_err), .fsm_state(fsm_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    Branch    = 1'b0;
    Zero      = 1'b0;
    Add       = $urandom;
    ALUResult = $urandom;
    ReadData2 = $urandom;
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
  endtask

  // One EX/MEM instruction: held while stall is high, replaced after the first unstalled cycle.
  task automatic run_op(input logic rd, input logic wr, input logic br, input logic zr,
                        input logic [31:0] tgt, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rdata, input int delay);
    bit   is_access, is_aligned, timed_out;
    int   n_access, stall_cycles;
    logic exp_we;
    @(negedge clk);
    MemRead = rd; MemWrite = wr; Branch = br; Zero = zr; Add = tgt;
    ALUResult = addr; ReadData2 = wdata;
    mem_ack = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    #1;
    is_access  = rd | wr;
    is_aligned = (addr[1:0] == 2'b00);
    check("branch_target", BranchTarget, tgt);
    check("rdo_before", ReadData_Out, exp_rdo);
    if (!is_access || !is_aligned) begin
      check("stall_no_access", {31'd0, stall}, 32'd0);
      check("req_no_access", {31'd0, mem_req}, 32'd0);
      check("pcsrc_free", {31'd0, PCSrc}, {31'd0, br & zr});
      @(negedge clk);
      idle_inputs();
      #1;
      check("align_err_pulse", {31'd0, align_err}, {31'd0, is_access});
      check("req_after_misalign", {31'd0, mem_req}, 32'd0);
      check("stall_after_misalign", {31'd0, stall}, 32'd0);
      @(negedge clk);
      #1;
      check("align_err_end", {31'd0, align_err}, 32'd0);
      return;
    end
    timed_out    = (delay >= TIMEOUT);
    n_access     = timed_out ? TIMEOUT : delay + 1;
    exp_we       = wr & ~rd;
    stall_cycles = stall ? 1 : 0;
    check("stall_detect", {31'd0, stall}, 32'd1);
    check("pcsrc_detect", {31'd0, PCSrc}, 32'd0);
    exp_q.push_back(rd ? (timed_out ? 32'd0 : rdata) : exp_rdo);
    for (int k = 0; k < n_access; k++) begin
      @(negedge clk);
      mem_ack   = (k == delay);
      mem_rdata = (k == delay) ? rdata : $urandom;
      #1;
      stall_cycles += stall ? 1 : 0;
      check("req_access", {31'd0, mem_req}, 32'd1);
      check("addr_access", mem_addr, addr);
      check("we_access", {31'd0, mem_we}, {31'd0, exp_we});
      check("wdata_access", mem_wdata, wdata);
      check("pcsrc_stalled", {31'd0, PCSrc}, 32'd0);
      check("mem_err_access", {31'd0, mem_err}, 32'd0);
      check("rdo_access", ReadData_Out, exp_rdo);
    end
    // Stray ack in DONE must be ignored.
    @(negedge clk);
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    #1;
    stall_cycles += stall ? 1 : 0;
    exp_rdo = exp_q.pop_front();
    check("req_done", {31'd0, mem_req}, 32'd0);
    check("stall_done", {31'd0, stall}, 32'd0);
    check("mem_err_done", {31'd0, mem_err}, {31'd0, timed_out});
    check("pcsrc_done", {31'd0, PCSrc}, {31'd0, br & zr});
    check("rdo_done", ReadData_Out, exp_rdo);
    check("stall_cycles", stall_cycles, 1 + n_access);
    @(negedge clk);
    idle_inputs();
    #1;
    check("req_after_done", {31'd0, mem_req}, 32'd0);
    check("mem_err_after_done", {31'd0, mem_err}, 32'd0);
    check("rdo_after_done", ReadData_Out, exp_rdo);
  endtask

  task automatic reset_mid_access();
    @(negedge clk);
    MemRead = 1'b1; MemWrite = 1'b0; ALUResult = 32'h0000_0080; ReadData2 = $urandom;
    Branch = 1'b1; Zero = 1'b1; mem_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("req_before_reset", {31'd0, mem_req}, 32'd1);
    reset = 1'b0;
    #1;
    exp_rdo = 32'd0;
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_rdo", ReadData_Out, 32'd0);
    check("rst_pcsrc", {31'd0, PCSrc}, 32'd1);
    @(negedge clk);
    #1;
    check("rst_hold_stall", {31'd0, stall}, 32'd0);
    check("rst_hold_req", {31'd0, mem_req}, 32'd0);
    idle_inputs();
    reset = 1'b1;
  endtask

  initial begin
    logic rd, wr;
    logic [31:0] addr;
    int delay;
    reset = 1'b0;
    idle_inputs();
    MemRead = 1'b1;
    ALUResult = 32'h0000_0100;
    exp_rdo = 32'd0;
    #1;
    check("reset_req", {31'd0, mem_req}, 32'd0);
    check("reset_stall", {31'd0, stall}, 32'd0);
    check("reset_addr", mem_addr, 32'd0);
    check("reset_wdata", mem_wdata, 32'd0);
    check("reset_rdo", ReadData_Out, 32'd0);
    check("reset_errs", {30'd0, align_err, mem_err}, 32'd0);
    check("reset_state", {30'd0, fsm_state}, 32'd0);
    repeat (2) @(negedge clk);
    idle_inputs();
    reset = 1'b1;

    run_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0040, $urandom, 32'hDEAD_BEEF, 0);
    run_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0010, 32'h1234_5678, $urandom, 3);
    run_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0042, $urandom, $urandom, 0);
    run_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0044, $urandom, $urandom, TIMEOUT);
    run_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0048, $urandom, 32'hCAFE_F00D, TIMEOUT - 1);
    run_op(1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0100, $urandom, $urandom, $urandom, 0);
    run_op(1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_004C, $urandom, 32'hA5A5_0001, 2);
    run_op(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0050, $urandom, 32'h0BAD_CAFE, 1);
    reset_mid_access();

    for (int i = 0; i < 50; i++) begin
      rd = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
      delay = ($urandom_range(0, 4) == 0) ? int'($urandom_range(TIMEOUT - 3, TIMEOUT + 2))
                                          : int'($urandom_range(0, 4));
      run_op(rd, wr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
             addr, $urandom, $urandom, delay);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
